// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: per-channel edge/level latch and mask, lowest index wins.
// Request reaches o_int two edges after the trigger; the presented ID stays frozen until i_ack.
module interrupt_controller #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_trigger,
  input  logic [NUM_IRQ-1:0] i_en,
  input  logic [NUM_IRQ-1:0] i_edge_mode,
  input  logic               i_global_en,
  input  logic               i_ack,
  output logic               o_int,
  output logic [ID_W-1:0]    o_id,
  output logic [NUM_IRQ-1:0] o_pending
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] trig_q;
  logic [NUM_IRQ-1:0] set_vec, clr_vec, eligible;

  // Edge channels need a low-to-high transition; level channels latch while high.
  assign set_vec  = i_en & i_trigger & (~i_edge_mode | ~trig_q);
  assign eligible = pending_q & i_en;

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_vec[i] = (state_q == ACTIVE) && i_ack && (id_q == ID_W'(i));
    end
    pending_d = set_vec | (pending_q & ~clr_vec);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (i_global_en && (eligible != '0)) begin
          state_d = ACTIVE;
          // Scan downward so the lowest set index is the final assignment.
          for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) id_d = ID_W'(i);
          end
        end
      end
      ACTIVE: begin
        if (i_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      pending_q <= '0;
      trig_q    <= i_trigger;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      trig_q    <= i_trigger;
    end
  end

  assign o_int     = (state_q == ACTIVE);
  assign o_id      = id_q;
  assign o_pending = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed plus randomized bench for interrupt_controller with a behavioural reference model.
module tb_interrupt_controller;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] trig, en, edge_m;
  logic         gen, ack;
  logic         o_int;
  logic [2:0]   o_id;
  logic [N-1:0] o_pending;

  int n_assert = 0;
  int n_fail   = 0;

  logic [N-1:0] m_pend, m_prev;
  bit           m_int;
  int           m_id;

  interrupt_controller #(.NUM_IRQ(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_trigger   (trig),
    .i_en        (en),
    .i_edge_mode (edge_m),
    .i_global_en (gen),
    .i_ack       (ack),
    .o_int       (o_int),
    .o_id        (o_id),
    .o_pending   (o_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: pending bits as a set, presentation as "busy with channel id or not".
  task automatic model_edge();
    logic [N-1:0] np;
    bit           ni;
    int           nid;
    if (!rst_n) begin
      m_pend = '0; m_int = 0; m_id = 0; m_prev = trig;
      return;
    end
    for (int i = 0; i < N; i++) begin
      bit rise, setb, clrb;
      rise  = trig[i] && !m_prev[i];
      setb  = en[i] && (edge_m[i] ? rise : trig[i]);
      clrb  = ack && m_int && (m_id == i);
      np[i] = setb || (m_pend[i] && !clrb);
    end
    ni = m_int; nid = m_id;
    if (!m_int) begin
      if (gen) begin
        for (int i = 0; i < N; i++) begin
          if (m_pend[i] && en[i]) begin
            ni = 1; nid = i;
            break;
          end
        end
      end
    end else if (ack) begin
      ni = 0;
    end
    m_pend = np; m_int = ni; m_id = nid; m_prev = trig;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_int", {31'd0, o_int}, {31'd0, m_int});
    if (m_int) chk("model_id", {29'd0, o_id}, m_id);
    chk("model_pending", {24'd0, o_pending}, {24'd0, m_pend});
  endtask

  initial begin
    m_pend = '0; m_prev = '0; m_int = 0; m_id = 0;
    rst_n = 1'b0; trig = 8'h01; en = 8'hFF; edge_m = 8'hFF; gen = 1'b1; ack = 1'b0;

    // Reset with ch0 already high: no edge after release.
    step(); step();
    chk("rst_int", {31'd0, o_int}, 32'd0);
    chk("rst_id", {29'd0, o_id}, 32'd0);
    chk("rst_pending", {24'd0, o_pending}, 32'h00);
    rst_n = 1'b1;
    step(); step(); step();
    chk("held_high_no_pending", {24'd0, o_pending}, 32'h00);
    chk("held_high_no_int", {31'd0, o_int}, 32'd0);
    trig = 8'h00; step();
    trig = 8'h01; step();
    chk("rearm_pending", {24'd0, o_pending}, 32'h01);
    step();
    chk("rearm_id", {29'd0, o_id}, 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    trig = 8'h00; step();

    // Single edge on ch3.
    trig = 8'h08; step();
    chk("ch3_pending", {24'd0, o_pending}, 32'h08);
    chk("ch3_not_yet", {31'd0, o_int}, 32'd0);
    trig = 8'h00; step();
    chk("ch3_int", {31'd0, o_int}, 32'd1);
    chk("ch3_id", {29'd0, o_id}, 32'd3);
    step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("ch3_ack_int", {31'd0, o_int}, 32'd0);
    chk("ch3_ack_pending", {24'd0, o_pending}, 32'h00);

    // Simultaneous ch5 and ch2.
    trig = 8'h24; step(); trig = 8'h00; step();
    chk("sim_first_id", {29'd0, o_id}, 32'd2);
    ack = 1'b1; step(); ack = 1'b0;
    chk("sim_gap_int", {31'd0, o_int}, 32'd0);
    chk("sim_ch5_pending", {24'd0, o_pending}, 32'h20);
    step();
    chk("sim_second_id", {29'd0, o_id}, 32'd5);
    ack = 1'b1; step(); ack = 1'b0;

    // No preemption: ch0 arrives while ch4 is active.
    trig = 8'h10; step(); trig = 8'h00; step();
    trig = 8'h01; step(); trig = 8'h00; step();
    chk("nopreempt_id", {29'd0, o_id}, 32'd4);
    ack = 1'b1; step(); ack = 1'b0;
    step();
    chk("after_preempt_id", {29'd0, o_id}, 32'd0);
    ack = 1'b1; step(); ack = 1'b0;

    // Level ch1 held high re-pends on ack; masking before ack stops it.
    edge_m = 8'hFD; trig = 8'h02; step(); step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("level_gap", {31'd0, o_int}, 32'd0);
    step();
    chk("level_again_id", {29'd0, o_id}, 32'd1);
    en = 8'hFD;
    ack = 1'b1; step(); ack = 1'b0;
    step();
    chk("level_masked_int", {31'd0, o_int}, 32'd0);
    chk("level_masked_pend", {31'd0, o_pending[1]}, 32'd0);
    trig = 8'h00; en = 8'hFF; edge_m = 8'hFF; step();

    // Masked pending ch6 with global disable, IDLE ack ignored.
    gen = 1'b0; trig = 8'h40; step(); trig = 8'h00; en = 8'hBF; step(); step();
    chk("mask_pend", {24'd0, o_pending}, 32'h40);
    ack = 1'b1; step(); ack = 1'b0;
    chk("idle_ack_pend", {24'd0, o_pending}, 32'h40);
    chk("idle_ack_int", {31'd0, o_int}, 32'd0);
    en = 8'hFF; gen = 1'b1; step();
    chk("reenable_id", {29'd0, o_id}, 32'd6);
    chk("reenable_int", {31'd0, o_int}, 32'd1);
    ack = 1'b1; step(); ack = 1'b0;

    // Reset during service.
    trig = 8'h01; step(); trig = 8'h00; step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_int", {31'd0, o_int}, 32'd0);
    chk("midrst_pend", {24'd0, o_pending}, 32'h00);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      trig   = N'($urandom);
      en     = N'($urandom) | N'($urandom);
      edge_m = N'($urandom);
      gen    = ($urandom_range(0, 7) != 0);
      ack    = ($urandom_range(0, 2) == 0);
      rst_n  = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Parametrised multi-channel interrupt controller: generalises the single-line latch/acknowledge filter to `NUM_IRQ` sources. Each source has a per-channel enable and a per-channel edge/level mode. Pending requests are arbitrated by fixed priority (index 0 highest). The winner is presented to the CPU core as `o_int` plus a stable `o_id`, which holds until the core acknowledges it.

## Interface
- `NUM_IRQ`, default 8: number of interrupt sources, 2..32.
- `ID_W`, default `$clog2(NUM_IRQ)`: width of the channel ID. Derived; do not override.

Ports (clock and reset first):
- `i_clk`  in  1: single clock, rising edge.
- `i_rst_n`  in  1: synchronous, active-low reset.
- `i_trigger`  in  `NUM_IRQ`: raw interrupt request lines, synchronous to `i_clk`.
- `i_en`  in  `NUM_IRQ`: per-channel enable (mask); 1 = enabled.
- `i_edge_mode`  in  `NUM_IRQ`: 1 = rising-edge sensitive, 0 = level sensitive.
- `i_global_en`  in  1: when 0, no new presentation starts; latching still occurs.
- `i_ack`  in  1: acknowledge pulse for the currently presented `o_id`.
- `o_int`  out  1: interrupt request to the core.
- `o_id`  out  `ID_W`: channel being presented; valid while `o_int` = 1.
- `o_pending`  out  `NUM_IRQ`: raw pending register, for status reads.

## Operation
Reset (`i_rst_n` = 0 at a rising edge):
- `pending` <= 0, `o_int` <= 0, `o_id` <= 0.
- Edge history `trig_q` <= `i_trigger`, so a line already high when reset releases produces no edge.

Set condition for channel i, `set[i]`:
- Requires `i_en[i]` = 1.
- Edge mode: `i_trigger[i] & ~trig_q[i]`.
- Level mode: `i_trigger[i]`.

Every non-reset cycle:
- `trig_q` <= `i_trigger`.
- `pending[i]` <= `set[i] | (pending[i] & ~clr[i])`.
- `clr[i]` = `i_ack & o_int & (o_id == i)`.
- Set wins over clear on the same channel in the same cycle.
- Level mode: a line still high when acked re-pends on that same edge.

Presentation FSM, two states:
- IDLE (`o_int` = 0):
  - `eligible` = `pending & i_en`.
  - If `i_global_en` and `eligible != 0`: `o_id` <= index of the lowest set bit, `o_int` <= 1, go to ACTIVE.
- ACTIVE (`o_int` = 1):
  - `o_id` is frozen. No preemption, even by a higher-priority channel.
  - Clearing `i_en[o_id]` or `i_global_en` does not withdraw the request.
  - `i_ack` = 1: `o_int` <= 0, clear `pending[o_id]`, go to IDLE.

Other rules:
- `i_ack` in IDLE is ignored: no state change, no pending cleared.
- Masked channels (`i_en` = 0) keep any existing pending bit but are not eligible. Re-enabling makes them eligible with no new trigger needed.
- `o_pending` reflects the register directly, masked bits included.

## Timing
Trigger to request:
- Trigger sampled at edge k sets `pending` after k.
- `o_int` rises after edge k+1 (2-cycle latency), provided the FSM is in IDLE and `i_global_en` = 1.

Acknowledge:
- `i_ack` sampled high at edge m drops `o_int` and the pending bit after m.
- Earliest next presentation is after edge m+1, so `o_int` is low for at least one cycle between services.

Back-to-back and simultaneous events:
- Back-to-back service of two pending channels: presented at cycles n and n+2 relative to each other's ack.
- Simultaneous triggers on several channels in one cycle: all latch; they are presented in ascending index order.

Mode and reset corner cases:
- Edge mode: a line held high yields exactly one pending set; it needs a low cycle to re-arm.
- `i_edge_mode` changes take effect on the next edge evaluation with no other side effects.
- Reset mid-service (`o_int` = 1) returns all outputs to reset values on that edge; the outstanding request is lost.

## Test plan
- Reset with `i_trigger` = 0x01 held high, edge mode, enabled: after reset release `o_pending` stays 0x00 and `o_int` stays 0 until the line drops and rises again.
- Edge on ch3 at edge k, all enabled, `i_global_en` = 1: `o_pending` = 0x08 after k; `o_int` = 1, `o_id` = 3 after k+1; ack at m gives `o_int` = 0, `o_pending` = 0x00 after m.
- Simultaneous edges on ch5 and ch2: presented `o_id` = 2 first; after ack, one idle cycle, then `o_id` = 5; ch5 stays pending throughout.
- While ACTIVE on ch4, a ch0 edge arrives: `o_id` stays 4 until ack, then ch0 is presented.
- Level ch1 held high, ack issued: `o_int` drops for one cycle and returns with `o_id` = 1. Same stimulus with `i_en[1]` = 0 before ack: no re-presentation, `o_pending[1]` = 0.
- ch6 triggers while `i_en[6]` = 1, then `i_en[6]` <= 0 before presentation with `i_global_en` = 0: `o_pending` = 0x40, `o_int` = 0. Re-enable both: `o_int` = 1, `o_id` = 6 one cycle later. `i_ack` pulsed in IDLE changes nothing.
